// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control path: instruction
// field encodings, ALU control codes, ALU operation selects and the
// controller state encoding.
package mips_defs;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Operation request from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Controller states (visible on the debug port)
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // True for every opcode this controller knows how to sequence
    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: turns the FSM's operation request plus the R-type funct
// field into a 4-bit ALU control code, and flags supported funct values.
import mips_defs::*;

module alu_decoder (
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [3:0] alu_control,
    output logic       funct_valid
);

    logic [3:0] funct_code;

    // Map the funct field to an ALU code; unsupported values fall back to ADD
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        funct_code  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_NOR:  funct_code = ALU_NOR;
            FN_SLT:  funct_code = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    // Select the fixed operation or the funct-derived one
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_code;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, drives the
// datapath selects and enables, and counts retired instructions.
import mips_defs::*;

module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state_q, state_d;
    logic       mem_is_lw;
    logic       funct_valid;
    logic       decode_illegal;
    logic       retire;
    aluop_t     aluop;

    // Unqualified per-state controls; enables are gated by reset below
    logic       mem_read_s, mem_write_s, ir_write_s, reg_write_s;
    logic       pc_write_s, branch_s;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .aluop       (aluop),
        .alu_control (ALUControl),
        .funct_valid (funct_valid)
    );

    // Unsupported opcode, or R-type with an unsupported funct, seen in DECODE
    assign decode_illegal = (state_q == S_DECODE) &&
                            (!opcode_supported(opcode) ||
                             ((opcode == OP_RTYPE) && !funct_valid));

    // States whose exit completes an instruction
    assign retire = (state_q == S_MEMWB)  || (state_q == S_MEMWR) ||
                    (state_q == S_ALUWB)  || (state_q == S_BRANCH) ||
                    (state_q == S_ADDIWB) || (state_q == S_JUMP);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Remember lw vs sw at DECODE, since opcode is not looked at in MEMADR
    always_ff @(posedge clk) begin
        // NOTE: no reset here; the flag is only read in MEMADR, which is
        // always entered from DECODE where the flag is written.
        if (state_q == S_DECODE) mem_is_lw <= (opcode == OP_LW);
    end

    // Retired-instruction counter; reset aborts and clears it
    always_ff @(posedge clk) begin
        if (rst)         instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (decode_illegal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = mem_is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode (ALU op in EXEC and PCEn in BRANCH add inputs)
    always_comb begin
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        aluop       = ALUOP_ADD;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ir_write_s = 1'b1;
                ALUSrcB    = 2'b01;
                pc_write_s = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                aluop    = ALUOP_SUB;
                PCSrc    = 2'b01;
                branch_s = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables and the illegal pulse are held low while reset is asserted
    assign MemRead  = mem_read_s  & ~rst;
    assign MemWrite = mem_write_s & ~rst;
    assign IRWrite  = ir_write_s  & ~rst;
    assign RegWrite = reg_write_s & ~rst;
    assign PCEn     = (pc_write_s | (branch_s & zero)) & ~rst;
    assign illegal  = decode_illegal & ~rst;

    assign state = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multicycle MIPS datapath. It replaces the hard-coded per-program control registers at top level.
- Reads opcode and funct from the instruction register, plus the ALU zero flag. Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath select and enable signal, plus a retired-instruction counter for test logic.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  data/instruction memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs data
- ALUSrcB  out  2  ALU B select: 00 = rt data, 01 = const 4, 10 = sext imm, 11 = sext imm << 2
- ALUControl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable: PCWrite OR (Branch AND zero)
- illegal  out  1  one-cycle pulse in DECODE when the opcode/funct is unsupported
- state  out  4  current state encoding (debug)
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Outputs are Moore, decoded from the state. Two exceptions: PCEn depends on zero in BRANCH, and ALUControl depends on funct in EXEC. Any output not listed for a state is 0, and ALUControl defaults to 0010.
- FETCH:
  - Outputs: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00, PCEn=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ADD.
  - Next state by opcode: 100011 lw / 101011 sw -> MEMADR; 000000 R-type -> EXEC; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP.
  - Any other opcode, or R-type with funct not in {100000, 100010, 100100, 100101, 100111, 101010}: illegal=1, next FETCH, no writes.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ADD.
  - Next state: MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1, MemRead=1; next MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
- MEMWR: IorD=1, MemWrite=1; next FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (add 0010, sub 0110, and 0000, or 0001, nor 1100, slt 0111).
  - Next state: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCEn=zero.
  - Next state: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD; next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
- JUMP: PCSrc=10, PCEn=1; next FETCH.
- Latency (cycles incl. FETCH): lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
- instr_count:
  - Increments by 1 on the rising edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - Does not increment for illegal instructions.
  - Wraps from all-ones to 0.
- opcode/funct are sampled only in DECODE and EXEC; values in other states are ignored.
- Reset:
  - While rst=1, every enable (MemRead, MemWrite, IRWrite, RegWrite, PCEn) and illegal is forced to 0.
  - On the next rising edge: state <= FETCH, instr_count <= 0.
  - Reset asserted mid-instruction aborts it: no writeback, no count increment. After rst deasserts, the first cycle is FETCH.

Decomposition:
- Shared package mips_defs holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
  - the 4-bit state encodings.
- One sub-module, alu_decoder:
  - Inputs: funct and an aluop (00 add, 01 sub, 10 funct).
  - Outputs: ALUControl and a funct_valid flag used by DECODE.

Test Plan:
- Reset, then opcode 100011 (lw) held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5; instr_count 0 -> 1.
- R-type with funct 100010 (sub) -> ALUControl=0110 in EXEC; ALUWB has RegDst=1, RegWrite=1; 4 cycles total.
- beq with zero=1 in BRANCH -> PCEn=1, PCSrc=01. Repeat with zero=0 -> PCEn=0; instr_count increments in both cases.
- Opcode 111111, or R-type funct 000111 -> illegal=1 in DECODE, back to FETCH next cycle, RegWrite/MemWrite never asserted, instr_count unchanged.
- rst asserted in MEMRD of an lw -> all enables 0 that cycle, FETCH on the next edge, no MEMWB, instr_count=0.
- Back-to-back sw, addi, j -> MemWrite=1 exactly once; RegWrite=1 in ADDIWB with RegDst=0; PCSrc=10 with PCEn=1 in JUMP; instr_count=3 after 11 cycles.
